// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared register map, STATUS/CTRL bit positions and FSM encoding
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_TIMEOUT   = 3;
  localparam int STAT_COUNT_LSB = 4;
  localparam int STAT_COUNT_W   = 5;
  localparam int STAT_BCNT_LSB  = 9;

  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLR   = 1;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/uart_rx_word_ctrl_if.sv
// ============================================================================
// Module  : uart_rx_word_ctrl_if
// Brief   : Byte-strobe input and CPU register bus of the word controller
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_word_ctrl_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [1:0]  addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output rx_data, rx_valid, addr, rd_en, wr_en, wdata,
    input  rdata, irq
  );

  modport slave (
    input  rx_data, rx_valid, addr, rd_en, wr_en, wdata,
    output rdata, irq
  );

endinterface

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// ============================================================================
// Module  : sync_fifo_param
// Brief   : Single-clock FIFO; flush wins, simultaneous push/pop legal when full
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_param #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop frees the slot being written, so a full FIFO may still accept a push.
  assign w_do_pop  = pop_i & ~empty_o & ~flush_i;
  assign w_do_push = push_i & ~flush_i & (~full_o | w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (w_do_push && !w_do_pop)      count_q <= count_q + 1'b1;
      else if (w_do_pop && !w_do_push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_word_ctrl.sv
// ============================================================================
// Module  : uart_rx_word_ctrl
// Brief   : Packs UART bytes into little-endian 32-bit words behind a CPU FIFO
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_word_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 104166
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_rx_word_ctrl_if.slave  bus
);

  localparam int               TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int               CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [31:0]     word_q, word_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            overrun_q, overrun_d;
  logic            timeout_err_q, timeout_err_d;

  logic            w_flush;
  logic            w_clr;
  logic            w_pop;
  logic            w_push;
  logic [31:0]     w_push_word;
  logic            w_timeout;
  logic [31:0]     w_head;
  logic [CW-1:0]   w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_unused_wdata;

  assign w_flush = bus.wr_en & (bus.addr == ADDR_CTRL) & bus.wdata[CTRL_FLUSH];
  assign w_clr   = bus.wr_en & (bus.addr == ADDR_CTRL) & bus.wdata[CTRL_CLR];
  assign w_pop   = bus.rd_en & (bus.addr == ADDR_DATA) & ~w_empty;
  assign w_unused_wdata = ^bus.wdata[31:2];

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    tmo_d       = tmo_q;
    w_push      = 1'b0;
    w_push_word = word_q;
    w_timeout   = 1'b0;
    if (w_flush) begin
      state_d    = IDLE;
      byte_cnt_d = 2'd0;
      word_d     = '0;
      tmo_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.rx_valid) begin
            word_d     = {24'd0, bus.rx_data};
            byte_cnt_d = 2'd1;
            tmo_d      = '0;
            state_d    = COLLECT;
          end
        end
        COLLECT: begin
          if (bus.rx_valid) begin
            tmo_d = '0;
            if (byte_cnt_q == 2'd3) begin
              w_push      = 1'b1;
              w_push_word = {bus.rx_data, word_q[23:0]};
              word_d      = '0;
              byte_cnt_d  = 2'd0;
              state_d     = IDLE;
            end else begin
              word_d[8*byte_cnt_q +: 8] = bus.rx_data;
              byte_cnt_d                = byte_cnt_q + 2'd1;
            end
          end else if (tmo_q == TMO_LAST) begin
            // Sender stalled mid-word: drop the fragment and flag it.
            w_timeout  = 1'b1;
            word_d     = '0;
            byte_cnt_d = 2'd0;
            tmo_d      = '0;
            state_d    = IDLE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Set beats clear when both land on the same edge.
  assign overrun_d     = (w_push & w_full & ~w_pop) | (overrun_q & ~w_clr);
  assign timeout_err_d = w_timeout | (timeout_err_q & ~w_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      byte_cnt_q    <= 2'd0;
      word_q        <= '0;
      tmo_q         <= '0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      word_q        <= word_d;
      tmo_q         <= tmo_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  sync_fifo_param #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_push),
    .data_i  (w_push_word),
    .pop_i   (w_pop),
    .flush_i (w_flush),
    .head_o  (w_head),
    .count_o (w_count),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      ADDR_DATA: bus.rdata = w_head;
      ADDR_STATUS: begin
        bus.rdata[STAT_NOT_EMPTY]                     = ~w_empty;
        bus.rdata[STAT_FULL]                          = w_full;
        bus.rdata[STAT_OVERRUN]                       = overrun_q;
        bus.rdata[STAT_TIMEOUT]                       = timeout_err_q;
        bus.rdata[STAT_COUNT_LSB +: STAT_COUNT_W]     = STAT_COUNT_W'(w_count);
        bus.rdata[STAT_BCNT_LSB +: 2]                 = byte_cnt_q;
      end
      default: bus.rdata = '0;
    endcase
  end

  assign bus.irq = ~w_empty | overrun_q | timeout_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_word_ctrl.sv
// ============================================================================
// Module  : tb_uart_rx_word_ctrl
// Brief   : Scoreboard bench: queue-based reference model, negedge read monitor
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_word_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_word_ctrl_if bus();

  uart_rx_word_ctrl #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [32:0] expq [$];   // {irq, rdata} expected for each issued read

  // Reference model: words waiting, bytes of the unfinished word, idle clocks since last byte
  logic [31:0] m_q    [$];
  logic [7:0]  m_part [$];
  int          m_idle = 0;
  bit          m_ov   = 1'b0;
  bit          m_to   = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] model_rdata(logic [1:0] a);
    logic [31:0] r;
    r = '0;
    if (a == 2'd0) begin
      if (m_q.size() > 0) r = m_q[0];
    end else if (a == 2'd1) begin
      r = 32'((m_q.size() > 0) ? 1 : 0) + 32'((m_q.size() == DEPTH) ? 2 : 0)
        + 32'(m_ov ? 4 : 0) + 32'(m_to ? 8 : 0)
        + 32'(m_q.size() * 16) + 32'(m_part.size() * 512);
    end
    return r;
  endfunction

  function automatic logic model_irq();
    return (m_q.size() > 0) || m_ov || m_to;
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_part.delete();
    m_idle = 0;
    m_ov   = 1'b0;
    m_to   = 1'b0;
  endfunction

  function automatic void model_step(bit rxv, logic [7:0] rxd, bit rd, bit wr,
                                     logic [1:0] a, logic [31:0] wd);
    bit flush    = wr && (a == 2'd2) && wd[0];
    bit clr      = wr && (a == 2'd2) && wd[1];
    bit popped   = rd && (a == 2'd0) && (m_q.size() > 0);
    bit was_full = (m_q.size() == DEPTH);
    bit set_ov   = 1'b0;
    bit set_to   = 1'b0;
    logic [31:0] w;
    if (flush) begin
      m_q.delete();
      m_part.delete();
      m_idle = 0;
    end else begin
      if (popped) void'(m_q.pop_front());
      if (rxv) begin
        m_part.push_back(rxd);
        m_idle = 0;
        if (m_part.size() == 4) begin
          w = {m_part[3], m_part[2], m_part[1], m_part[0]};
          m_part.delete();
          if (was_full && !popped) set_ov = 1'b1;
          else m_q.push_back(w);
        end
      end else if (m_part.size() > 0) begin
        m_idle++;
        if (m_idle == TMO) begin
          m_part.delete();
          m_idle = 0;
          set_to = 1'b1;
        end
      end
    end
    m_ov = set_ov || (m_ov && !clr);
    m_to = set_to || (m_to && !clr);
  endfunction

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic cyc(input bit rxv, input logic [7:0] rxd, input bit rd, input bit wr,
                     input logic [1:0] a, input logic [31:0] wd);
    bus.rx_valid = rxv;
    bus.rx_data  = rxd;
    bus.rd_en    = rd;
    bus.wr_en    = wr;
    bus.addr     = a;
    bus.wdata    = wd;
    if (rd) expq.push_back({model_irq(), model_rdata(a)});
    @(posedge clk);
    model_step(rxv, rxd, rd, wr, a, wd);
    #1;
    bus.rx_valid = 1'b0;
    bus.rd_en    = 1'b0;
    bus.wr_en    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    cyc(1'b1, b, 1'b0, 1'b0, 2'd3, 32'd0);
    idle(gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic rd(input logic [1:0] a);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic wr_ctrl(input logic [31:0] d);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'd2, d);
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n && bus.rd_en) begin
      if (expq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_read: got %h expected none", bus.rdata);
      end else begin
        e = expq.pop_front();
        check($sformatf("rdata_addr%0d", bus.addr), bus.rdata, e[31:0]);
        check("irq", {31'd0, bus.irq}, {31'd0, e[32]});
      end
    end
  end

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    summary();
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          rxv, rdn, wrn;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] words [5];

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rd_en    = 1'b0;
    bus.wr_en    = 1'b0;
    bus.addr     = 2'd1;
    bus.wdata    = 32'd0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_status", bus.rdata, 32'd0);
    check("reset_irq", {31'd0, bus.irq}, 32'd0);
    bus.addr = 2'd0;
    #1;
    check("reset_data", bus.rdata, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word assembly
    send_byte(8'h11, 4);
    send_byte(8'h22, 4);
    send_byte(8'h33, 4);
    send_byte(8'h44, 0);
    rd(2'd1);
    rd(2'd0);
    rd(2'd1);
    rd(2'd2);
    rd(2'd3);
    rd(2'd0);

    // Overflow: fifth word dropped
    for (int k = 0; k < 5; k++) words[k] = $urandom;
    for (int k = 0; k < 4; k++) send_word(words[k], 0);
    rd(2'd1);
    send_word(words[4], 1);
    rd(2'd1);
    for (int k = 0; k < 4; k++) rd(2'd0);
    rd(2'd1);
    wr_ctrl(32'h2);
    rd(2'd1);

    // Partial-word timeout
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 0);
    idle(TMO - 1);
    rd(2'd1);
    idle(1);
    rd(2'd1);
    send_word(32'h04030201, 2);
    rd(2'd0);
    wr_ctrl(32'h2);
    rd(2'd1);

    // Pop coincides with the completing byte while full
    for (int k = 0; k < 4; k++) send_word($urandom, 0);
    wd = $urandom;
    for (int k = 0; k < 3; k++) send_byte(wd[8*k +: 8], 0);
    cyc(1'b1, wd[31:24], 1'b1, 1'b0, 2'd0, 32'd0);
    rd(2'd1);
    for (int k = 0; k < 4; k++) rd(2'd0);
    rd(2'd1);

    // Flush + clear with a partial word pending
    send_word($urandom, 0);
    send_byte(8'h5A, 0);
    send_byte(8'hA5, 0);
    idle(TMO + 2);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    wr_ctrl(32'h3);
    rd(2'd1);

    // Asynchronous reset mid-word with data queued
    send_word($urandom, 0);
    send_byte(8'h77, 0);
    send_byte(8'h88, 0);
    bus.addr = 2'd1;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_status", bus.rdata, 32'd0);
    check("async_reset_irq", {31'd0, bus.irq}, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_word(32'hDEADBEEF, 1);
    rd(2'd0);
    rd(2'd1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rxv = ($urandom_range(0, 2) == 0);
      rdn = ($urandom_range(0, 3) == 0);
      wrn = ($urandom_range(0, 29) == 0);
      a   = 2'($urandom_range(0, 3));
      if (wrn && ($urandom_range(0, 3) != 0)) a = 2'd2;
      wd  = $urandom;
      cyc(rxv, 8'($urandom), rdn, wrn, a, wd);
      if ($urandom_range(0, 120) == 0) idle(TMO - 1 + $urandom_range(0, 2));
    end

    idle(3);
    n_checks++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
    end
    summary();
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_word_ctrl.md
UART_RX_WORD_CTRL -- requirements
Module: uart_rx_word_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, is the number of 32-bit word entries; it SHALL be a power of two, 2..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 104166, is the number of idle clocks after a byte before a partial word is discarded (two byte times at 9600 baud, 50 MHz).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; asynchronous assertion, active-low.
REQ-005 rx_data  input  8  received byte from the UART receiver output register.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_data is valid in the same cycle.
REQ-007 addr  input  2  CPU register select: 0 = DATA, 1 = STATUS, 2 = CTRL, 3 = reserved.
REQ-008 rd_en  input  1  CPU read strobe; a read pops the FIFO only when addr = DATA.
REQ-009 wr_en  input  1  CPU write strobe; acts only when addr = CTRL.
REQ-010 wdata  input  32  CPU write data.
REQ-011 rdata  output  32  read data, combinational from addr and current state.
REQ-012 irq  output  1  level interrupt, equal to not_empty OR overrun OR timeout_err.

Function
REQ-013 The byte-assembly FSM SHALL have two states: IDLE (byte_cnt = 0) and COLLECT (byte_cnt = 1..3).
- IDLE, rx_valid: the byte is stored in word[7:0], byte_cnt becomes 1, the FSM moves to COLLECT.
- COLLECT, rx_valid: the byte is stored in word[8*byte_cnt +: 8], byte_cnt increments.
- Byte order is little-endian: the first byte received is bits [7:0].
REQ-014 On the 4th byte edge, the complete word SHALL be pushed into the FIFO on that same edge, and the FSM SHALL return to IDLE with byte_cnt = 0.
- not_empty and the FIFO head are visible in the cycle after the strobe.
REQ-015 In COLLECT, a counter SHALL reload to 0 on every rx_valid and increment otherwise.
- When the count reaches TIMEOUT_CYCLES-1 with no rx_valid, the partial word SHALL be discarded, byte_cnt SHALL become 0, timeout_err SHALL be set, and the FSM SHALL return to IDLE.
- If rx_valid arrives in that same cycle, it is processed normally and no timeout occurs.
REQ-016 The counter SHALL hold at 0 while the FSM is in IDLE.
REQ-017 Push while full with no pop in the same cycle: the word SHALL be dropped, FIFO contents SHALL be unchanged, and overrun SHALL be set (sticky).
REQ-018 Push and pop in the same cycle SHALL both succeed at any fill level, including full; the count is unchanged.
REQ-019 Pop is rd_en AND addr = DATA AND not_empty; a read of DATA while empty SHALL return 0 and change no state.
REQ-020 rdata by register:
- DATA: the FIFO head (the word popped at the next edge).
- STATUS: [0] not_empty, [1] full, [2] overrun, [3] timeout_err, [8:4] count, [10:9] byte_cnt, other bits 0.
- CTRL and reserved: read as 0.
REQ-021 CTRL write, wdata[0] = 1 (flush): FIFO count SHALL become 0, the pointers SHALL reset, and the partial word SHALL be discarded (FSM to IDLE).
- Flush has priority over a simultaneous push, pop or rx_valid; that byte is lost.
REQ-022 CTRL write, wdata[1] = 1: overrun and timeout_err SHALL be cleared, unless the same edge sets them again, in which case set wins.
REQ-023 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH, with full = (count = FIFO_DEPTH).

Reset
REQ-024 While rst = 0, the following SHALL hold:
- FSM in IDLE, byte_cnt = 0, word = 0, timeout counter = 0.
- FIFO pointers and count = 0; overrun = 0, timeout_err = 0.
- Consequently irq = 0 and STATUS reads 0.
REQ-025 Reset asserted mid-word or with the FIFO non-empty SHALL discard all contents; after release, the next rx_valid SHALL be treated as byte 0.
REQ-026 FIFO storage array contents need not be reset; rdata for DATA SHALL be 0 whenever the FIFO is empty.

Structure
REQ-027 Shared package uart_pkg SHALL hold:
- register address constants (ADDR_DATA, ADDR_STATUS, ADDR_CTRL);
- STATUS bit indices and CTRL bit indices (CTRL_FLUSH = 0, CTRL_CLR = 1);
- the FSM state encoding (IDLE, COLLECT).
REQ-028 The word FIFO SHALL be a sub-module, sync_fifo_param, with parameters width and depth, ports push, pop, flush, head, count, full and empty, and the same clk and rst.
REQ-029 Assembly FSM, timeout counter, flags and register decode SHALL live in uart_rx_word_ctrl.

Verification (TIMEOUT_CYCLES = 20 for simulation)
REQ-030 Bytes 0x11, 0x22, 0x33, 0x44 as strobes, spaced 5 clocks -> STATUS = 0x011; DATA reads 0x44332211; next STATUS = 0x000.
REQ-031 Five words pushed without reads -> after the 4th word STATUS[1] = 1 and count = 4; the 5th word is dropped and overrun = 1; four DATA reads return the first four words in order.
REQ-032 Bytes 0xAA, 0xBB, then 20 idle clocks -> timeout_err = 1 and byte_cnt = 0; bytes 01, 02, 03, 04 then yield DATA = 0x04030201.
REQ-033 FIFO full; a DATA pop coincides with the 4th-byte strobe -> count stays 4, overrun stays 0, and order is preserved.
REQ-034 Two bytes received, then CTRL write 0x3 -> STATUS = 0 and irq = 0; rst pulled low mid-word clears all state asynchronously without waiting for a clock edge.
